// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter block: the per-request
// shift operation bundle and the saturating statistics counter helper.
package shift_arb_pkg;

    localparam int N_BITS  = 32;
    localparam int N_REQ   = 4;
    localparam int SHAMT_W = $clog2(N_BITS);
    localparam int ID_W    = $clog2(N_REQ);
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [N_BITS-1:0]  d;
        logic [SHAMT_W-1:0] shamt;
        logic               right;
        logic               arith;
    } shift_op_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/shift.sv
// Combinational barrel shifter: left, logical right or arithmetic right.
// Arithmetic left is the same as logical left.
module shift #(
    parameter int N_bits = 32
) (
    input  logic [N_bits-1:0]         i_d,
    input  logic [$clog2(N_bits)-1:0] i_shamt,
    input  logic                      i_right,
    input  logic                      i_arith,
    output logic [N_bits-1:0]         o_d
);

    logic signed [N_bits-1:0] w_sd;

    assign w_sd = $signed(i_d);

    always_comb begin
        o_d = '0;
        if (!i_right)
            o_d = i_d << i_shamt;
        else if (i_arith)
            o_d = $unsigned(w_sd >>> i_shamt);
        else
            o_d = i_d >> i_shamt;
    end

endmodule

// File: rtl/shift_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker. Searches from i_ptr upward
// with wrap-around and returns the first valid requester.
module rr_pick #(
    parameter  int N_req = 4,
    localparam int ID_BITS = $clog2(N_req)
) (
    input  logic [N_req-1:0]   i_valid,
    input  logic [ID_BITS-1:0] i_ptr,
    output logic [N_req-1:0]   o_grant,
    output logic [ID_BITS-1:0] o_idx,
    output logic               o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < N_req; k++) begin
            j = (int'(i_ptr) + k) % N_req;
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = ID_BITS'(j);
            end
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin share of one shift datapath between N_req
// requesters, with a registered result channel. Optional per-requester grant
// counters are enabled by defining SHIFT_ARB_STATS_EN.
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter  int N_bits  = N_BITS,
    parameter  int N_req   = N_REQ,
    localparam int SH_BITS = $clog2(N_bits),
    localparam int ID_BITS = $clog2(N_req)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [N_req-1:0]                req_valid,
    output logic [N_req-1:0]                req_ready,
    input  logic [N_req-1:0][N_bits-1:0]    req_d,
    input  logic [N_req-1:0][SH_BITS-1:0]   req_shamt,
    input  logic [N_req-1:0]                req_right,
    input  logic [N_req-1:0]                req_arith,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [N_bits-1:0]               res_d,
`ifdef SHIFT_ARB_STATS_EN
    output logic [ID_BITS-1:0]              res_id,
    output logic [N_req-1:0][CNT_W-1:0]     grant_cnt
`else
    output logic [ID_BITS-1:0]              res_id
`endif
);

    logic               r_res_valid;
    logic [N_bits-1:0]  r_res_d;
    logic [ID_BITS-1:0] r_res_id;
    logic [ID_BITS-1:0] r_rr_ptr;

    logic [N_req-1:0]   w_grant;
    logic [ID_BITS-1:0] w_idx;
    logic               w_any;
    logic               w_can_accept;
    logic               w_xfer;
    shift_op_t          w_op;
    logic [N_bits-1:0]  w_shifted;

    rr_pick #(.N_req(N_req)) u_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Reset suppresses any grant so nothing transfers on a reset edge.
    assign w_can_accept = !r_res_valid || res_ready;
    assign w_xfer       = w_any && w_can_accept && !rst;
    assign req_ready    = w_xfer ? w_grant : '0;

    always_comb begin
        w_op = '{d:     req_d[w_idx],
                 shamt: req_shamt[w_idx],
                 right: req_right[w_idx],
                 arith: req_arith[w_idx]};
    end

    shift #(.N_bits(N_bits)) u_shift (
        .i_d     (w_op.d),
        .i_shamt (w_op.shamt),
        .i_right (w_op.right),
        .i_arith (w_op.arith),
        .o_d     (w_shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_d     <= '0;
            r_res_id    <= '0;
            r_rr_ptr    <= '0;
        end else if (w_xfer) begin
            r_res_valid <= 1'b1;
            r_res_d     <= w_shifted;
            r_res_id    <= w_idx;
            r_rr_ptr    <= (w_idx == ID_BITS'(N_req - 1)) ? '0 : w_idx + 1'b1;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign res_valid = r_res_valid;
    assign res_d     = r_res_d;
    assign res_id    = r_res_id;

`ifdef SHIFT_ARB_STATS_EN
    logic [N_req-1:0][CNT_W-1:0] r_grant_cnt;

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_req; i++) begin
            if (rst)
                r_grant_cnt[i] <= '0;
            else if (req_ready[i])
                r_grant_cnt[i] <= sat_inc(r_grant_cnt[i]);
        end
    end

    assign grant_cnt = r_grant_cnt;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios plus randomized
// traffic compared against a cycle-level reference model built from the rules.
module tb_shift_arbiter;

    localparam int NB = 32;
    localparam int NR = 4;
    localparam int SW = 5;
    localparam int IW = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic [NR-1:0][NB-1:0]    req_d;
    logic [NR-1:0][SW-1:0]    req_shamt;
    logic [NR-1:0]            req_right;
    logic [NR-1:0]            req_arith;
    logic                     res_valid;
    logic                     res_ready;
    logic [NB-1:0]            res_d;
    logic [IW-1:0]            res_id;
`ifdef SHIFT_ARB_STATS_EN
    logic [NR-1:0][15:0]      grant_cnt;
`endif

    always #5 clk = ~clk;

    shift_arbiter #(.N_bits(NB), .N_req(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_d     (req_d),
        .req_shamt (req_shamt),
        .req_right (req_right),
        .req_arith (req_arith),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_d     (res_d),
`ifdef SHIFT_ARB_STATS_EN
        .res_id    (res_id),
        .grant_cnt (grant_cnt)
`else
        .res_id    (res_id)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit            m_valid;
    logic [NB-1:0] m_d;
    int            m_id;
    int            m_ptr;
    int            m_cnt [NR];
    logic [NR-1:0] last_acc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NB-1:0] ref_shift(input logic [NB-1:0] d, input int sh,
                                                 input bit right, input bit arith);
        logic [NB-1:0] r;
        if (!right) return d << sh;
        r = d >> sh;
        if (arith && d[NB-1]) r = r | ~(32'hFFFF_FFFF >> sh);
        return r;
    endfunction

    task automatic set_req(input int i, input logic [NB-1:0] d, input int sh,
                           input bit right, input bit arith);
        req_d[i]     = d;
        req_shamt[i] = SW'(sh);
        req_right[i] = right;
        req_arith[i] = arith;
    endtask

    task automatic rand_payload(input int i);
        logic [NB-1:0] d;
        d = $urandom;
        if ($urandom_range(0, 7) == 0) d = 32'h8000_0000;
        set_req(i, d, $urandom_range(0, 31), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Called just after a falling edge with inputs set; checks, then advances one cycle.
    task automatic step();
        logic [NR-1:0] er;
        int  w;
        bit  found;
        bit  can;
        #2;
        can   = !m_valid || res_ready;
        found = 0;
        w     = 0;
        for (int k = 0; k < NR; k++) begin
            int j;
            j = (m_ptr + k) % NR;
            if (!found && req_valid[j]) begin
                found = 1;
                w     = j;
            end
        end
        er = '0;
        if (!rst && found && can) er[w] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("res_valid", 64'(res_valid), 64'(m_valid));
        chk("res_d",     64'(res_d),     64'(m_d));
        chk("res_id",    64'(res_id),    64'(m_id));
`ifdef SHIFT_ARB_STATS_EN
        for (int i = 0; i < NR; i++) chk("grant_cnt", 64'(grant_cnt[i]), 64'(m_cnt[i]));
`endif
        @(posedge clk);
        if (rst) begin
            m_valid = 0; m_d = '0; m_id = 0; m_ptr = 0;
            for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        end else if (er != '0) begin
            m_valid = 1;
            m_d     = ref_shift(req_d[w], int'(req_shamt[w]), req_right[w], req_arith[w]);
            m_id    = w;
            m_ptr   = (w + 1) % NR;
            if (m_cnt[w] < 65535) m_cnt[w]++;
        end else if (res_ready) begin
            m_valid = 0;
        end
        last_acc = er;
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_d     = '0;
        req_shamt = '0;
        req_right = '0;
        req_arith = '0;
        res_ready = 1'b1;
        last_acc  = '0;
        m_valid = 0; m_d = '0; m_id = 0; m_ptr = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        @(negedge clk);

        // reset cycle: requests present but nothing may be granted
        req_valid = 4'b1111;
        step();
        step();
        rst = 1'b0;

        // all four continuously valid: ids rotate 0,1,2,3,...
        for (int i = 0; i < NR; i++) rand_payload(i);
        for (int c = 0; c < 8; c++) begin
            step();
            chk("rr_seq_id", 64'(res_id), 64'(c % NR));
            chk("rr_seq_valid", 64'(res_valid), 64'd1);
        end

        // single request from requester 2, arithmetic right
        req_valid = 4'b0100;
        set_req(2, 32'h8000_0001, 4, 1'b1, 1'b1);
        step();
        req_valid = 4'b0000;
        chk("single_d", 64'(res_d), 64'h0000_0000_F800_0000);
        chk("single_id", 64'(res_id), 64'd2);
        req_valid = 4'b1111;
        #2 chk("single_next_ptr", 64'(req_ready), 64'b1000);
        step();

        // logical left and logical right
        req_valid = 4'b0001;
        set_req(0, 32'h0000_00FF, 8, 1'b0, 1'b0);
        step();
        req_valid = 4'b0000;
        chk("log_left", 64'(res_d), 64'h0000_FF00);
        req_valid = 4'b0001;
        set_req(0, 32'hF000_0000, 31, 1'b1, 1'b0);
        step();
        req_valid = 4'b0000;
        chk("log_right", 64'(res_d), 64'h1);
        step();

        // backpressure with a held result, then release with no bubble
        req_valid = 4'b1111;
        step();
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2 chk("bp_ready", 64'(req_ready), 64'd0);
            step();
        end
        res_ready = 1'b1;
        step();

        // reset mid-stream while a result is held
        res_ready = 1'b0;
        step();
        req_valid = 4'b1010;
        rst = 1'b1;
        step();
        rst = 1'b0;
        res_ready = 1'b1;
        #2;
        chk("rst_mid_valid", 64'(res_valid), 64'd0);
        chk("rst_first_grant", 64'(req_ready), 64'b0010);
        step();

        // randomized traffic, requesters hold payload until accepted
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || last_acc[i]) begin
                    req_valid[i] = 1'($urandom_range(0, 1));
                    rand_payload(i);
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            step();
        end

`ifdef SHIFT_ARB_STATS_EN
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b0001;
        res_ready = 1'b1;
        repeat (70000) @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        chk("cnt_sat_0", 64'(grant_cnt[0]), 64'hFFFF);
        for (int i = 1; i < NR; i++) chk("cnt_other", 64'(grant_cnt[i]), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
